xorshift_checker: RTL and testbench

//   Receive-side checker for the xorshift generator's output stream. Locks onto
//   an incoming word stream, predicts each next word with the same recurrence,
//   and reports lock status, per-word mismatch pulses and saturating counters.

---
 rtl/xorshift_checker.sv | 140 ++++++++++++++
 tb/tb_xorshift_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xorshift_checker.sv
// xorshift_checker
// Receive-side checker for an xorshift test-traffic stream. It hunts for a
// run of correctly predicted words, locks, then free-runs its own prediction
// and counts matches and mismatches until too many consecutive errors drop
// the lock.
module xorshift_checker #(
  parameter int WIDTH         = 32,
  parameter int SHIFT_A       = 13,
  parameter int SHIFT_B       = 17,
  parameter int SHIFT_C       = 5,
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_ERRORS = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 data_valid,
  input  logic [WIDTH-1:0]     data,
  input  logic                 clear,
  output logic                 locked,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [CNT_WIDTH-1:0] match_count
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_ERRORS + 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } stateT;

  stateT                stateQ;
  logic [WIDTH-1:0]     predQ;
  logic                 predValidQ;
  logic [GW-1:0]        goodRunQ;
  logic [BW-1:0]        badRunQ;
  logic                 errorQ;
  logic [CNT_WIDTH-1:0] errCntQ;
  logic [CNT_WIDTH-1:0] matchCntQ;

  logic [WIDTH-1:0]     dataNext;
  logic [WIDTH-1:0]     predNext;
  logic                 huntMatch;
  logic                 lockMatch;
  logic [GW-1:0]        goodRunD;
  logic [BW-1:0]        badRunD;
  logic [CNT_WIDTH-1:0] errCntD;
  logic [CNT_WIDTH-1:0] matchCntD;

  // One step of the xorshift recurrence, every intermediate truncated to WIDTH.
  function automatic logic [WIDTH-1:0] nextWord(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] y;
    y = x;
    y = y ^ (y << SHIFT_A);
    y = y ^ (y >> SHIFT_B);
    y = y ^ (y << SHIFT_C);
    return y;
  endfunction

  // Successor words, compare results and saturating/incremented run and count values.
  // A zero word can never be part of a live stream, so it never counts as a
  // locked match even if the prediction were somehow zero.
  always_comb begin
    dataNext  = nextWord(data);
    predNext  = nextWord(predQ);
    huntMatch = predValidQ && (data == predQ);
    lockMatch = (data == predQ) && (data != '0);
    goodRunD  = goodRunQ + GW'(1);
    badRunD   = badRunQ + BW'(1);
    errCntD   = (errCntQ == '1) ? errCntQ : errCntQ + CNT_WIDTH'(1);
    matchCntD = (matchCntQ == '1) ? matchCntQ : matchCntQ + CNT_WIDTH'(1);
  end

  // Hunt/lock state machine together with prediction, run lengths, error pulse
  // and counters; clear is applied last so it overrides a same-edge increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ     <= HUNT;
      predQ      <= '0;
      predValidQ <= 1'b0;
      goodRunQ   <= '0;
      badRunQ    <= '0;
      errorQ     <= 1'b0;
      errCntQ    <= '0;
      matchCntQ  <= '0;
    end else begin
      errorQ <= 1'b0;
      if (data_valid) begin
        case (stateQ)
          HUNT: begin
            if (huntMatch) begin
              goodRunQ <= goodRunD;
              predQ    <= dataNext;
              if (goodRunD == GW'(LOCK_COUNT)) begin
                stateQ  <= LOCKED;
                badRunQ <= '0;
              end
            end else if (data != '0) begin
              predQ      <= dataNext;
              predValidQ <= 1'b1;
              goodRunQ   <= '0;
            end else begin
              predValidQ <= 1'b0;
              goodRunQ   <= '0;
            end
          end
          LOCKED: begin
            predQ <= predNext;
            if (lockMatch) begin
              matchCntQ <= matchCntD;
              badRunQ   <= '0;
            end else begin
              errorQ  <= 1'b1;
              errCntQ <= errCntD;
              badRunQ <= badRunD;
              if (badRunD == BW'(UNLOCK_ERRORS)) begin
                stateQ     <= HUNT;
                predValidQ <= 1'b0;
                goodRunQ   <= '0;
              end
            end
          end
          default: stateQ <= HUNT;
        endcase
      end
      if (clear) begin
        errCntQ   <= '0;
        matchCntQ <= '0;
      end
    end
  end

  assign locked      = (stateQ == LOCKED);
  assign error       = errorQ;
  assign error_count = errCntQ;
  assign match_count = matchCntQ;

endmodule

// File: tb/tb_xorshift_checker.sv
// Testbench for xorshift_checker (WIDTH=32, CNT_WIDTH=4 so saturation is reachable).
module tb_xorshift_checker;

  localparam int CW = 4;

  logic          clk;
  logic          reset_n;
  logic          data_valid;
  logic [31:0]   data;
  logic          clear;
  logic          locked;
  logic          error;
  logic [CW-1:0] error_count;
  logic [CW-1:0] match_count;

  typedef struct {
    logic          valid;
    logic [31:0]   data;
    logic          clr;
    logic          expLocked;
    logic          expError;
    logic [CW-1:0] expErrCnt;
    logic [CW-1:0] expMatchCnt;
  } vecT;

  typedef struct {
    logic          locked;
    logic          error;
    logic [CW-1:0] errCnt;
    logic [CW-1:0] matchCnt;
  } expT;

  int          compared;
  int          mismatched;
  expT         sbQ[$];
  logic [31:0] seq[0:79];
  vecT         tableA[$];
  vecT         tableB[$];

  xorshift_checker #(
    .WIDTH(32), .SHIFT_A(13), .SHIFT_B(17), .SHIFT_C(5),
    .LOCK_COUNT(4), .UNLOCK_ERRORS(3), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .data_valid(data_valid),
    .data(data),
    .clear(clear),
    .locked(locked),
    .error(error),
    .error_count(error_count),
    .match_count(match_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run never reaches its summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] xsNext(input logic [31:0] x);
    logic [31:0] t;
    t = x;
    t = t ^ (t << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  function automatic vecT mk(input logic v, input logic [31:0] d, input logic c,
                             input logic l, input logic e, input int ec, input int mc);
    vecT r;
    r.valid       = v;
    r.data        = d;
    r.clr         = c;
    r.expLocked   = l;
    r.expError    = e;
    r.expErrCnt   = CW'(ec);
    r.expMatchCnt = CW'(mc);
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pops the oldest expectation and compares it with the DUT outputs.
  task automatic checkOutput(input string tag);
    expT e;
    if (sbQ.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sbQ.pop_front();
      cmp({tag, " locked"},      32'(locked),      32'(e.locked));
      cmp({tag, " error"},       32'(error),       32'(e.error));
      cmp({tag, " error_count"}, 32'(error_count), 32'(e.errCnt));
      cmp({tag, " match_count"}, 32'(match_count), 32'(e.matchCnt));
    end
  endtask

  // Drives one cycle of inputs, queues its expected result, checks after the edge.
  task automatic applyStimulus(input vecT v, input string tag);
    expT e;
    @(negedge clk);
    data_valid = v.valid;
    data       = v.data;
    clear      = v.clr;
    e.locked   = v.expLocked;
    e.error    = v.expError;
    e.errCnt   = v.expErrCnt;
    e.matchCnt = v.expMatchCnt;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must drop at once.
  task automatic doReset(input string tag);
    @(negedge clk);
    data_valid = 1'b0;
    clear      = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    cmp({tag, " locked"},      32'(locked),      32'd0);
    cmp({tag, " error"},       32'(error),       32'd0);
    cmp({tag, " error_count"}, 32'(error_count), 32'd0);
    cmp({tag, " match_count"}, 32'(match_count), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b1;
    data_valid = 1'b0;
    data       = '0;
    clear      = 1'b0;

    seq[0] = 32'd1;
    for (int i = 1; i < 80; i++) seq[i] = xsNext(seq[i-1]);

    // Acquisition, single bit error, burst error with unlock and relock.
    tableA.push_back(mk(1, seq[0],  0, 0, 0, 0, 0));
    tableA.push_back(mk(1, seq[1],  0, 0, 0, 0, 0));
    tableA.push_back(mk(1, seq[2],  0, 0, 0, 0, 0));
    tableA.push_back(mk(1, seq[3],  0, 0, 0, 0, 0));
    tableA.push_back(mk(1, seq[4],  0, 1, 0, 0, 0));
    tableA.push_back(mk(1, seq[5],  0, 1, 0, 0, 1));
    tableA.push_back(mk(1, seq[6],  0, 1, 0, 0, 2));
    tableA.push_back(mk(1, seq[7],  0, 1, 0, 0, 3));
    tableA.push_back(mk(1, seq[8] ^ 32'h0000_1000, 0, 1, 1, 1, 3));
    tableA.push_back(mk(1, seq[9],  0, 1, 0, 1, 4));
    tableA.push_back(mk(1, seq[10], 0, 1, 0, 1, 5));
    tableA.push_back(mk(0, 32'hFFFF_FFFF, 1, 1, 0, 0, 0));
    tableA.push_back(mk(1, seq[11] ^ 32'h8000_0000, 0, 1, 1, 1, 0));
    tableA.push_back(mk(1, seq[12] ^ 32'h0000_0001, 0, 1, 1, 2, 0));
    tableA.push_back(mk(1, seq[13] ^ 32'h0001_0000, 0, 0, 1, 3, 0));
    tableA.push_back(mk(1, seq[14], 0, 0, 0, 3, 0));
    tableA.push_back(mk(1, seq[15], 0, 0, 0, 3, 0));
    tableA.push_back(mk(1, seq[16], 0, 0, 0, 3, 0));
    tableA.push_back(mk(1, seq[17], 0, 0, 0, 3, 0));
    tableA.push_back(mk(1, seq[18], 0, 1, 0, 3, 0));
    tableA.push_back(mk(1, seq[19], 0, 1, 0, 3, 1));

    // Zeros never lock; gaps hold the prediction; a zero while locked is an error.
    for (int i = 0; i < 6; i++) tableB.push_back(mk(1, 32'd0, 0, 0, 0, 0, 0));
    tableB.push_back(mk(1, seq[20], 0, 0, 0, 0, 0));
    tableB.push_back(mk(0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0));
    tableB.push_back(mk(1, seq[21], 0, 0, 0, 0, 0));
    tableB.push_back(mk(0, seq[23], 0, 0, 0, 0, 0));
    tableB.push_back(mk(1, seq[22], 0, 0, 0, 0, 0));
    tableB.push_back(mk(1, seq[23], 0, 0, 0, 0, 0));
    tableB.push_back(mk(1, seq[24], 0, 1, 0, 0, 0));
    tableB.push_back(mk(0, 32'h1234_5678, 0, 1, 0, 0, 0));
    tableB.push_back(mk(1, seq[25], 0, 1, 0, 0, 1));
    tableB.push_back(mk(0, 32'd0, 0, 1, 0, 0, 1));
    tableB.push_back(mk(1, seq[26], 0, 1, 0, 0, 2));
    tableB.push_back(mk(1, 32'd0,   0, 1, 1, 1, 2));
    tableB.push_back(mk(0, seq[28], 0, 1, 0, 1, 2));
    tableB.push_back(mk(1, seq[28], 0, 1, 0, 1, 3));

    doReset("reset");

    for (int i = 0; i < tableA.size(); i++)
      applyStimulus(tableA[i], $sformatf("tableA[%0d]", i));

    doReset("reset2");

    for (int i = 0; i < tableB.size(); i++)
      applyStimulus(tableB[i], $sformatf("tableB[%0d]", i));

    // Saturation: 20 mismatches interleaved with matches, then clear racing a mismatch.
    applyStimulus(mk(0, 32'd0, 1, 1, 0, 0, 0), "satClear");
    for (int i = 0; i < 20; i++) begin
      int ec;
      int mcBefore;
      int mcAfter;
      ec       = (i + 1 > 15) ? 15 : i + 1;
      mcBefore = (i > 15) ? 15 : i;
      mcAfter  = (i + 1 > 15) ? 15 : i + 1;
      applyStimulus(mk(1, seq[29 + 2*i] ^ 32'h0000_0100, 0, 1, 1, ec, mcBefore),
                    $sformatf("sat bad %0d", i));
      applyStimulus(mk(1, seq[30 + 2*i], 0, 1, 0, ec, mcAfter),
                    $sformatf("sat good %0d", i));
    end
    applyStimulus(mk(1, seq[69] ^ 32'h0000_0002, 1, 1, 1, 0, 0), "clearVsError");
    applyStimulus(mk(1, seq[70], 0, 1, 0, 0, 1), "afterClear");

    // Asynchronous reset while locked, then a full relock run is required.
    doReset("midLockReset");
    applyStimulus(mk(1, seq[71], 0, 0, 0, 0, 0), "relock 0");
    applyStimulus(mk(1, seq[72], 0, 0, 0, 0, 0), "relock 1");
    applyStimulus(mk(1, seq[73], 0, 0, 0, 0, 0), "relock 2");
    applyStimulus(mk(1, seq[74], 0, 0, 0, 0, 0), "relock 3");
    applyStimulus(mk(1, seq[75], 0, 1, 0, 0, 0), "relock 4");
    applyStimulus(mk(1, seq[76], 0, 1, 0, 0, 1), "relock 5");

    @(negedge clk);
    data_valid = 1'b0;
    if (sbQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard drain: got %0d entries, expected 0", sbQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
